// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with round-robin replacement and whole-cache invalidate.
// Optional macro ICACHE_PERF_EN adds the hitcnt/misscnt performance counter ports.
module icache_assoc #(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt,
`endif
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
  localparam int unsigned CNT_W = (WORDS > 1) ? OFF_W : 1;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [IDX_W-1:0]   miss_idx_q;
  logic [WAY_W-1:0]   victim_q;
  logic               flush_pend_q;

  logic               valid_q [SETS][WAYS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [31:0]        data_q  [SETS][WAYS][WORDS];
  logic [WAY_W-1:0]   ptr_q   [SETS];
  logic [31:0]        buf_q   [WORDS];

  logic [31:0]        word_a;
  logic [CNT_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               lookup_hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;
  logic               victim_found;
  logic               miss_start, beat, commit;
  logic [31:0]        fill_addr;

  // Address split: word offset, set index, tag above both.
  assign word_a  = imemaddr >> 2;
  assign req_off = CNT_W'(word_a & 32'(WORDS - 1));
  assign req_idx = IDX_W'(word_a >> OFF_W);
  assign req_tag = TAG_W'(word_a >> (OFF_W + IDX_W));

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lookup_hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way first, else the set's round-robin pointer.
  always_comb begin
    victim_found = 1'b0;
    victim       = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[req_idx][w]) begin
        victim_found = 1'b1;
        victim       = WAY_W'(w);
      end
    end
    if (!victim_found) victim = ptr_q[req_idx];
  end

  assign ihit     = (state_q == IDLE) && imemREN && lookup_hit;
  assign imemload = ihit ? data_q[req_idx][hit_way][req_off] : 32'd0;

  assign fill_addr = ((32'(miss_tag_q) << (OFF_W + IDX_W)) |
                      (32'(miss_idx_q) << OFF_W) |
                      32'(cnt_q)) << 2;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_start = 1'b0;
    beat       = 1'b0;
    commit     = 1'b0;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit) begin
          state_d    = FILL;
          miss_start = 1'b1;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_addr;
        if (!iwait) begin
          beat  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        commit  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (miss_start) begin
        miss_tag_q <= req_tag;
        miss_idx_q <= req_idx;
        victim_q   <= victim;
      end
      if (state_q == DONE)                   flush_pend_q <= 1'b0;
      else if (iflush && (state_q != IDLE))  flush_pend_q <= 1'b1;
      // A flush seen at any point of a fill leaves the new line invalid too.
      if (((state_q == IDLE) && iflush) || (commit && (flush_pend_q || iflush))) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end else if (commit) begin
        valid_q[miss_idx_q][victim_q] <= 1'b1;
      end
      if (commit && (victim_q == ptr_q[miss_idx_q]))
        ptr_q[miss_idx_q] <= (WAYS == 1) ? '0 : ptr_q[miss_idx_q] + WAY_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (beat) buf_q[cnt_q] <= iload;
    if (commit) begin
      tag_q[miss_idx_q][victim_q] <= miss_tag_q;
      for (int d = 0; d < WORDS; d++) data_q[miss_idx_q][victim_q][d] <= buf_q[d];
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hitcnt  <= '0;
      misscnt <= '0;
    end else begin
      if (ihit)       hitcnt  <= hitcnt + 32'd1;
      if (miss_start) misscnt <= misscnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters (8 sets, 2 ways, 2-word blocks).
module tb_icache_assoc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        iflush = 1'b0;
  logic        iwait = 1'b0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
`ifdef ICACHE_PERF_EN
  logic [31:0] hitcnt;
  logic [31:0] misscnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign iload = memw(iaddr);

  icache_assoc dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
`ifdef ICACHE_PERF_EN
    .hitcnt   (hitcnt),
    .misscnt  (misscnt),
`endif
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    imemREN = 1'b0;
    iflush = 1'b0;
    iwait = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Present a miss on a and follow the fill through DONE.
  task automatic fill(input logic [31:0] a, input int stall, input bit flush_mid);
    logic [31:0] base;
    base = a & ~32'h7;
    @(negedge CLK);
    imemREN = 1'b1;
    imemaddr = a;
    iwait = 1'b0;
    #1 chk("miss_ihit", 32'(ihit), 32'd0);
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < ((b == 0) ? stall : 0); s++) begin
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        chk("stall_iren", 32'(iREN), 32'd1);
        chk("stall_iaddr", iaddr, base + 32'(4 * b));
        chk("stall_ihit", 32'(ihit), 32'd0);
      end
      @(negedge CLK);
      iwait = 1'b0;
      iflush = flush_mid && (b == 1);
      #1;
      chk("beat_iren", 32'(iREN), 32'd1);
      chk("beat_iaddr", iaddr, base + 32'(4 * b));
    end
    @(negedge CLK);
    iflush = 1'b0;
    #1;
    chk("done_iren", 32'(iREN), 32'd0);
    chk("done_ihit", 32'(ihit), 32'd0);
  endtask

  task automatic chk_hit(input logic [31:0] a, input bit exp_hit);
    @(negedge CLK);
    imemREN = 1'b1;
    imemaddr = a;
    #1;
    chk("lookup_ihit", 32'(ihit), 32'(exp_hit));
    chk("lookup_data", imemload, exp_hit ? memw(a) : 32'd0);
    if (!exp_hit) imemREN = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Cold miss then same-block hits.
    fill(32'h40, 0, 1'b0);
    chk_hit(32'h40, 1'b1);
    chk_hit(32'h44, 1'b1);

    // Flush in IDLE: same-cycle hit still reported, next cycle misses.
    @(negedge CLK);
    imemREN = 1'b1;
    imemaddr = 32'h44;
    iflush = 1'b1;
    #1 chk("flush_same_cycle_hit", 32'(ihit), 32'd1);
    @(negedge CLK);
    iflush = 1'b0;
    #1 chk("flush_after_hit", 32'(ihit), 32'd0);
    imemREN = 1'b0;

    // Round-robin eviction in set 0.
    do_reset();
    fill(32'h00, 0, 1'b0);
    fill(32'h80, 0, 1'b0);
    chk_hit(32'h00, 1'b1);
    fill(32'h100, 0, 1'b0);
    chk_hit(32'h80, 1'b1);
    chk_hit(32'h100, 1'b1);
    chk_hit(32'h00, 1'b0);

    // Stalled first beat.
    do_reset();
    fill(32'h40, 5, 1'b0);
    chk_hit(32'h40, 1'b1);
    chk_hit(32'h44, 1'b1);

    // Flush during a fill leaves the new line invalid and wipes the rest.
    fill(32'h200, 0, 1'b1);
    chk_hit(32'h200, 1'b0);
    chk_hit(32'h40, 1'b0);
    fill(32'h200, 0, 1'b0);
    chk_hit(32'h204, 1'b1);

    // Reset during the second beat.
    @(negedge CLK);
    imemREN = 1'b1;
    imemaddr = 32'h40;
    iwait = 1'b0;
    @(negedge CLK);
    #1 chk("rstfill_beat0_iaddr", iaddr, 32'h40);
    @(negedge CLK);
    #1 chk("rstfill_beat1_iaddr", iaddr, 32'h44);
    #2 RST = 1'b1;
    #1;
    chk("rstfill_iren", 32'(iREN), 32'd0);
    chk("rstfill_iaddr", iaddr, 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    fill(32'h40, 0, 1'b0);
    chk_hit(32'h40, 1'b1);

`ifdef ICACHE_PERF_EN
    do_reset();
    fill(32'h40, 0, 1'b0);
    chk_hit(32'h40, 1'b1);
    chk_hit(32'h44, 1'b1);
    chk_hit(32'h40, 1'b1);
    @(negedge CLK);
    imemREN = 1'b0;
    #1;
    chk("perf_hitcnt", hitcnt, 32'd3);
    chk("perf_misscnt", misscnt, 32'd1);
    iflush = 1'b1;
    @(negedge CLK);
    iflush = 1'b0;
    #1;
    chk("perf_hitcnt_flush", hitcnt, 32'd3);
    chk("perf_misscnt_flush", misscnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
